bcd_serial_adder: RTL

Parametrised multi-digit BCD adder for the calculator datapath, successor to the single-digit modulo-10 add. Operands of `DIGITS` packed BCD digits are processed digit-serially, least-significant digit first, one digit per clock, with a ripple carry held in a register between digits. It adds carry-out, invalid-digit detection, a start/busy/done handshake and optional subtraction.

---
 rtl/bcd_serial_adder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder, LSD first, one digit per clock.
// Define BCD_SUB_EN to enable nines'-complement subtraction via op.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                op,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] res,
    output logic                cout,
    output logic                err
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic [W-1:0]   acc;
    logic [4:0]     idx;
    logic           carry;
    logic           errq;
    logic           last;
    logic           c0;
    logic [3:0]     da;
    logic [3:0]     db;
    logic [3:0]     dbc;
    logic [3:0]     rd;
    logic [4:0]     s;
    logic [4:0]     sm;
    logic           cn;
    logic           bad;
    logic [W+3:0]   cat;

`ifdef BCD_SUB_EN
    logic rop;
    assign c0 = op;
`else
    logic op_unused;
    assign op_unused = op;
    assign c0 = 1'b0;
`endif

    assign last = (idx == 5'(DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last)  state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Invalid digits count as zero; the sticky error records them.
    always_comb begin
        bad = (ra[3:0] > 4'd9) || (rb[3:0] > 4'd9);
        da  = (ra[3:0] > 4'd9) ? 4'd0 : ra[3:0];
        db  = (rb[3:0] > 4'd9) ? 4'd0 : rb[3:0];
`ifdef BCD_SUB_EN
        dbc = rop ? (4'd9 - db) : db;
`else
        dbc = db;
`endif
        s   = {1'b0, da} + {1'b0, dbc} + {4'd0, carry};
        sm  = s - 5'd10;
        if (s > 5'd9) begin
            rd = sm[3:0];
            cn = 1'b1;
        end else begin
            rd = s[3:0];
            cn = 1'b0;
        end
        cat = {rd, acc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra    <= '0;
            rb    <= '0;
            acc   <= '0;
            idx   <= '0;
            carry <= 1'b0;
            errq  <= 1'b0;
            res   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef BCD_SUB_EN
            rop   <= 1'b0;
`endif
        end else begin
            busy <= (state_n != IDLE);
            done <= (state_n == DONE);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        acc   <= '0;
                        idx   <= '0;
                        errq  <= 1'b0;
                        carry <= c0;
`ifdef BCD_SUB_EN
                        rop   <= op;
`endif
                    end
                end
                RUN: begin
                    ra    <= ra >> 4;
                    rb    <= rb >> 4;
                    acc   <= cat[W+3:4];
                    carry <= cn;
                    errq  <= errq | bad;
                    idx   <= idx + 5'd1;
                    // Publish on entry to DONE so outputs align with done.
                    if (last) begin
                        res  <= cat[W+3:4];
                        cout <= cn;
                        err  <= errq | bad;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
